// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one byte-level UART transmitter among NUM_REQ producers.
// Optional UART_ARB_LOCK_EN adds a per-requester lock that keeps the pointer on the sender for multi-byte messages.
module uart_tx_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 8,
    parameter int IDX_W   = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
`ifdef UART_ARB_LOCK_EN
    input  logic [NUM_REQ-1:0]        lock,
`endif
    input  logic                      tx_busy,
    input  logic                      tx_done,
    output logic [NUM_REQ-1:0]        gnt,
    output logic                      tx_start,
    output logic [DATA_W-1:0]         tx_data,
    output logic                      busy,
    output logic [IDX_W-1:0]          last_idx
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } state_t;

    // Modulo-NUM_REQ addition of two requester indices.
    function automatic logic [IDX_W-1:0] wrap_add(input logic [IDX_W-1:0] base,
                                                  input logic [IDX_W-1:0] offs);
        logic [IDX_W:0] sum;
        sum = {1'b0, base} + {1'b0, offs};
        if (sum >= (IDX_W+1)'(NUM_REQ)) begin
            sum = sum - (IDX_W+1)'(NUM_REQ);
        end
        return sum[IDX_W-1:0];
    endfunction

    state_t               r_state;
    logic [IDX_W-1:0]     r_ptr;
    logic [IDX_W-1:0]     r_last_idx;
    logic [DATA_W-1:0]    r_tx_data;
    logic [NUM_REQ-1:0]   r_gnt;
    logic                 r_tx_start;
    logic                 r_busy;

    state_t               w_state_next;
    logic [IDX_W-1:0]     w_ptr_next;
    logic [IDX_W-1:0]     w_last_idx_next;
    logic [DATA_W-1:0]    w_tx_data_next;
    logic [NUM_REQ-1:0]   w_gnt_next;
    logic                 w_tx_start_next;
    logic                 w_busy_next;

    logic [DATA_W-1:0]    w_bytes [NUM_REQ];
    logic [NUM_REQ-1:0]   w_rot;
    logic [IDX_W-1:0]     w_off;
    logic [IDX_W-1:0]     w_sel;
    logic                 w_any;
    logic                 w_lock_hit;

    // w_rot[k] is the request of the requester k positions after the pointer.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_slice
            assign w_bytes[gi] = req_data[gi*DATA_W +: DATA_W];
            assign w_rot[gi]   = req[wrap_add(r_ptr, IDX_W'(gi))];
        end
    endgenerate

    always_comb begin
        w_off = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (w_rot[k]) begin
                w_off = IDX_W'(k);
            end
        end
    end

    assign w_any = |req;
    assign w_sel = wrap_add(r_ptr, w_off);

`ifdef UART_ARB_LOCK_EN
    assign w_lock_hit = lock[r_last_idx];
`else
    assign w_lock_hit = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_ptr      <= '0;
            r_last_idx <= '0;
            r_tx_data  <= '0;
            r_gnt      <= '0;
            r_tx_start <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_ptr      <= w_ptr_next;
            r_last_idx <= w_last_idx_next;
            r_tx_data  <= w_tx_data_next;
            r_gnt      <= w_gnt_next;
            r_tx_start <= w_tx_start_next;
            r_busy     <= w_busy_next;
        end
    end

    always_comb begin
        w_state_next    = r_state;
        w_ptr_next      = r_ptr;
        w_last_idx_next = r_last_idx;
        w_tx_data_next  = r_tx_data;
        w_gnt_next      = '0;
        w_tx_start_next = 1'b0;
        w_busy_next     = r_busy;
        case (r_state)
            S_IDLE: begin
                if (w_any && !tx_busy) begin
                    w_state_next        = S_WAIT;
                    w_tx_data_next      = w_bytes[w_sel];
                    w_gnt_next[w_sel]   = 1'b1;
                    w_tx_start_next     = 1'b1;
                    w_last_idx_next     = w_sel;
                    w_busy_next         = 1'b1;
                end
            end
            S_WAIT: begin
                // r_last_idx still holds the requester whose frame just finished.
                if (tx_done) begin
                    w_state_next = S_IDLE;
                    w_busy_next  = 1'b0;
                    w_ptr_next   = w_lock_hit ? r_last_idx : wrap_add(r_last_idx, IDX_W'(1));
                end
            end
            default: begin
                w_state_next = S_IDLE;
                w_busy_next  = 1'b0;
            end
        endcase
    end

    assign gnt      = r_gnt;
    assign tx_start = r_tx_start;
    assign tx_data  = r_tx_data;
    assign busy     = r_busy;
    assign last_idx = r_last_idx;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: reset, single grant, round-robin order, wrap/skip, busy hold-off, reset mid-frame, optional lock.
module tb_uart_tx_arbiter;

    localparam int NR = 4;
    localparam int DW = 8;
    localparam int IW = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic [NR-1:0]     req;
    logic [NR*DW-1:0]  req_data;
`ifdef UART_ARB_LOCK_EN
    logic [NR-1:0]     lock;
`endif
    logic              tx_busy;
    logic              tx_done;
    logic [NR-1:0]     gnt;
    logic              tx_start;
    logic [DW-1:0]     tx_data;
    logic              busy;
    logic [IW-1:0]     last_idx;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    uart_tx_arbiter #(
        .NUM_REQ (NR),
        .DATA_W  (DW),
        .IDX_W   (IW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .req_data (req_data),
`ifdef UART_ARB_LOCK_EN
        .lock     (lock),
`endif
        .tx_busy  (tx_busy),
        .tx_done  (tx_done),
        .gnt      (gnt),
        .tx_start (tx_start),
        .tx_data  (tx_data),
        .busy     (busy),
        .last_idx (last_idx)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One edge in IDLE with a request pending must produce this grant.
    task automatic expect_grant(input string tag, input logic [NR-1:0] eg,
                                input logic [DW-1:0] ed, input logic [IW-1:0] ei);
        tick();
        $display("grant %s: gnt=%b tx_start=%0b tx_data=%h last_idx=%0d busy=%0b",
                 tag, gnt, tx_start, tx_data, last_idx, busy);
        chk({tag, ".gnt"},      32'(gnt),      32'(eg));
        chk({tag, ".tx_start"}, 32'(tx_start), 32'd1);
        chk({tag, ".tx_data"},  32'(tx_data),  32'(ed));
        chk({tag, ".last_idx"}, 32'(last_idx), 32'(ei));
        chk({tag, ".busy"},     32'(busy),     32'd1);
    endtask

    task automatic finish_frame(input string tag, input int hold);
        tx_busy = 1'b1;
        tick();
        chk({tag, ".wait_gnt"},   32'(gnt),      32'd0);
        chk({tag, ".wait_start"}, 32'(tx_start), 32'd0);
        chk({tag, ".wait_busy"},  32'(busy),     32'd1);
        repeat (hold - 1) tick();
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        tx_busy = 1'b0;
        chk({tag, ".done_busy"},  32'(busy),     32'd0);
        chk({tag, ".done_gnt"},   32'(gnt),      32'd0);
        chk({tag, ".done_start"}, 32'(tx_start), 32'd0);
    endtask

    initial begin
        rst      = 1'b1;
        req      = '0;
        req_data = {8'h13, 8'h12, 8'h5A, 8'h10};
        tx_busy  = 1'b0;
        tx_done  = 1'b0;
`ifdef UART_ARB_LOCK_EN
        lock     = '0;
`endif
        tick();
        tick();
        rst = 1'b0;
        chk("reset.gnt",      32'(gnt),      32'd0);
        chk("reset.tx_start", 32'(tx_start), 32'd0);
        chk("reset.tx_data",  32'(tx_data),  32'd0);
        chk("reset.busy",     32'(busy),     32'd0);
        chk("reset.last_idx", 32'(last_idx), 32'd0);

        // Single request from requester 1; pointer then sits at 2.
        req = 4'b0010;
        expect_grant("single", 4'b0010, 8'h5A, 2'd1);
        req = 4'b0000;
        finish_frame("single", 5);
        chk("single.data_hold", 32'(tx_data), 32'h5A);

        // 0111 grants 2 only when the pointer is 2.
        req = 4'b0111;
        expect_grant("ptr2", 4'b0100, 8'h12, 2'd2);
        req = 4'b0000;
        finish_frame("ptr2", 4);

        // Pointer 3, 0101: wrap to 0, then skip 1 to reach 2.
        req = 4'b0101;
        expect_grant("wrap0", 4'b0001, 8'h10, 2'd0);
        finish_frame("wrap0", 4);
        expect_grant("skip2", 4'b0100, 8'h12, 2'd2);
        req = 4'b0000;
        finish_frame("skip2", 4);

        // 1001 grants 3 only when the pointer is 3; pointer then wraps to 0.
        req = 4'b1001;
        expect_grant("ptr3", 4'b1000, 8'h13, 2'd3);
        req = 4'b0000;
        finish_frame("ptr3", 4);

        req_data = {8'h13, 8'h12, 8'h11, 8'h10};
        req = 4'b1111;
        expect_grant("rr0", 4'b0001, 8'h10, 2'd0);
        finish_frame("rr0", 20);
        expect_grant("rr1", 4'b0010, 8'h11, 2'd1);
        finish_frame("rr1", 20);
        expect_grant("rr2", 4'b0100, 8'h12, 2'd2);
        finish_frame("rr2", 20);
        expect_grant("rr3", 4'b1000, 8'h13, 2'd3);
        finish_frame("rr3", 20);
        expect_grant("rr4", 4'b0001, 8'h10, 2'd0);
        req = 4'b0000;
        finish_frame("rr4", 20);

        // Transmitter busy: request must wait; pointer is 1 so 0001 wraps to 0.
        tx_busy = 1'b1;
        req = 4'b0001;
        for (int i = 0; i < 5; i++) begin
            tick();
            $display("holdoff cycle %0d: gnt=%b tx_start=%0b", i, gnt, tx_start);
            chk("holdoff.gnt",      32'(gnt),      32'd0);
            chk("holdoff.tx_start", 32'(tx_start), 32'd0);
        end
        tx_busy = 1'b0;
        expect_grant("holdoff", 4'b0001, 8'h10, 2'd0);
        req = 4'b0000;
        finish_frame("holdoff", 3);

        // Reset three cycles into a frame abandons it and clears the pointer.
        req = 4'b0010;
        expect_grant("rstmid", 4'b0010, 8'h11, 2'd1);
        req = 4'b0000;
        tx_busy = 1'b1;
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tx_busy = 1'b0;
        $display("after mid-frame reset: gnt=%b tx_start=%0b tx_data=%h busy=%0b last_idx=%0d",
                 gnt, tx_start, tx_data, busy, last_idx);
        chk("rstmid.gnt",      32'(gnt),      32'd0);
        chk("rstmid.tx_start", 32'(tx_start), 32'd0);
        chk("rstmid.tx_data",  32'(tx_data),  32'd0);
        chk("rstmid.busy",     32'(busy),     32'd0);
        chk("rstmid.last_idx", 32'(last_idx), 32'd0);
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        chk("idle_done.gnt",      32'(gnt),      32'd0);
        chk("idle_done.tx_start", 32'(tx_start), 32'd0);
        chk("idle_done.busy",     32'(busy),     32'd0);
        tick();
        chk("idle_noreq.gnt", 32'(gnt), 32'd0);
        // 1001 grants 0 only when the pointer was cleared to 0.
        req = 4'b1001;
        expect_grant("rstptr", 4'b0001, 8'h10, 2'd0);
        req = 4'b0000;
        finish_frame("rstptr", 3);

`ifdef UART_ARB_LOCK_EN
        req = 4'b1000;
        expect_grant("lk_pre", 4'b1000, 8'h13, 2'd3);
        req = 4'b0000;
        finish_frame("lk_pre", 3);
        req  = 4'b0011;
        lock = 4'b0001;
        expect_grant("lock_a", 4'b0001, 8'h10, 2'd0);
        finish_frame("lock_a", 5);
        expect_grant("lock_b", 4'b0001, 8'h10, 2'd0);
        finish_frame("lock_b", 5);
        lock = 4'b0000;
        expect_grant("lock_c", 4'b0001, 8'h10, 2'd0);
        finish_frame("lock_c", 5);
        expect_grant("lock_d", 4'b0010, 8'h11, 2'd1);
        req = 4'b0000;
        finish_frame("lock_d", 5);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Round-robin arbiter sharing one byte-level UART transmitter among NUM_REQ requesters.
- Captures the winning requester's byte and issues a one-cycle start pulse to the transmitter.
- Holds off further grants until the transmitter reports the frame done.
- Sits between on-chip byte producers (command echo, status reporter, debug) and the single UART TX line, on the same clock as the UART receiver.

Parameters:
- NUM_REQ, 4, number of requesters; legal range 2..8.
- DATA_W, 8, byte width per requester.
- IDX_W, 2, width of the requester index; must equal clog2(NUM_REQ).

Ports:
- clk  input  1  system clock; all logic on its rising edge.
- rst  input  1  synchronous, active-high reset.
- req  input  NUM_REQ  per-requester request; bit i high means req_data slice i holds a valid byte.
- req_data  input  NUM_REQ*DATA_W  flattened bytes; requester i occupies bits [i*DATA_W +: DATA_W].
- tx_busy  input  1  transmitter busy (frame in progress).
- tx_done  input  1  one-cycle pulse at the end of the transmitter's stop bit.
- gnt  output  NUM_REQ  one-hot, one-cycle pulse; byte from that requester has been captured.
- tx_start  output  1  one-cycle pulse to the transmitter; coincident with gnt.
- tx_data  output  DATA_W  byte to transmit; stable from tx_start until the next capture.
- busy  output  1  high while a granted byte is outstanding (state WAIT).
- last_idx  output  IDX_W  index of the most recently granted requester.

Behaviour:
- Reset (rst high at a clock edge): gnt=0, tx_start=0, tx_data=0, busy=0, last_idx=0, round-robin pointer ptr=0, state=IDLE.
- Reset mid-transfer abandons the outstanding byte; any tx_done arriving afterwards in IDLE is ignored.
- All outputs are registered.
- FSM has two states, IDLE and WAIT.
- IDLE:
  - If any req bit is high and tx_busy=0, select sel = first set bit of req scanning ptr, ptr+1, …, wrapping modulo NUM_REQ.
  - Next edge: tx_data<=req_data[sel], gnt[sel]<=1, tx_start<=1, last_idx<=sel, busy<=1, state<=WAIT.
  - If tx_busy=1 or req=0, remain in IDLE with no outputs asserted.
- WAIT:
  - gnt and tx_start return to 0 after their single cycle; new req changes are ignored.
  - On tx_done=1: ptr<=(sel+1) mod NUM_REQ, busy<=0, state<=IDLE.
- Latency: req high in IDLE with tx_busy low gives gnt/tx_start one edge later.
- Minimum of one IDLE cycle between tx_done and the next tx_start. Requests seen together with tx_done are arbitrated on the following cycle using the updated ptr.
- Handshake: the requester holds req and its data stable until it sees its gnt bit.
  - It drops req the cycle after gnt, or keeps it high to queue the next byte.
  - A request withdrawn before gnt is legal; the request is simply not served.
- Fairness: a continuously requesting requester waits at most NUM_REQ-1 other frames.
- Wrap: sel=NUM_REQ-1 sets ptr to 0.
- tx_done while in IDLE is ignored. tx_start is never issued while tx_busy=1.

Optional Feature:
- Macro: UART_ARB_LOCK_EN.
- When defined:
  - Adds input lock (NUM_REQ bits).
  - If lock[sel]=1 when tx_done is seen in WAIT, ptr is set to sel instead of sel+1, so the same requester wins again if its req is still high. This lets multi-byte messages go out without interleaving.
  - If that requester's req is low on the next IDLE cycle, normal scanning from ptr=sel applies.
- When undefined: no lock port, and ptr always advances as described above.

Test Plan:
- Single request: req=4'b0010, req_data slice1=8'h5A, tx_busy=0 -> next cycle gnt=4'b0010, tx_start=1, tx_data=8'h5A, busy=1. After the tx_done pulse, busy=0 and ptr=2.
- Round-robin: req=4'b1111 held, bytes 8'h10/8'h11/8'h12/8'h13, tx_done 20 cycles after each start -> grant order 0,1,2,3,0. tx_data sequence 10,11,12,13,10.
- Wrap and skip: ptr=3, req=4'b0101 -> grant 0 first, then 2. ptr ends at 3.
- Busy hold-off: tx_busy=1 with req=4'b0001 for 5 cycles -> no gnt and no tx_start. Grant comes one cycle after tx_busy falls.
- Reset mid-WAIT: rst pulsed 3 cycles after tx_start -> all outputs 0, ptr=0. A tx_done pulse afterwards gives no grant unless req is high.
- Lock (UART_ARB_LOCK_EN): req=4'b0011, lock=4'b0001 for 2 frames then 0 -> grant order 0,0,0,1.
